// File: rtl/harq_soft_combine.sv
// harq_soft_combine -- HARQ soft-LLR combiner with ping/pong accumulation banks.
//
// A combine request latches the selected user's Ncb and waits for the readout
// side to release the target bank. The first pass over the circular buffer
// stores sign-extended LLRs (FILL); later passes add new LLRs onto the stored
// sums (COMBINE). The row flagged last ends the block, the finished bank is
// reported and the write bank flips.
//
// Optional feature: define HARQ_COMB_SAT_EN to saturate COMBINE sums and
// report clipping on o_sat_flag; otherwise sums wrap and o_sat_flag is 0.
//
// Ports:
//   i_core_clk   clock                   i_rx_rst     sync active-high reset
//   i_comb_req   start-combine pulse     i_user_idx   user selector
//   i_users_ncb  per-user Ncb, 16b each  i_harq_free  target bank released
//   i_llr_valid  LLR row valid           i_llr_data   LANES signed LLRs
//   i_llr_last   final row of the block  o_rdm_req    data-request pulse
//   o_comb_busy  FSM not idle            o_comb_done  completion pulse
//   o_done_bank  bank just completed     o_sat_flag   sticky clip indicator
//   i_rd_bank    readout bank            i_rd_addr    readout row
//   o_rd_data    readout row data, one cycle after address
module harq_soft_combine #(
    parameter int LANES     = 16,
    parameter int LLR_W     = 6,
    parameter int ACC_W     = 10,
    parameter int ADDR_W    = 11,
    parameter int NUM_USERS = 8
) (
    input  logic                         i_core_clk,
    input  logic                         i_rx_rst,
    input  logic                         i_comb_req,
    input  logic [$clog2(NUM_USERS)-1:0] i_user_idx,
    input  logic [16*NUM_USERS-1:0]      i_users_ncb,
    input  logic                         i_harq_free,
    input  logic                         i_llr_valid,
    input  logic [LANES*LLR_W-1:0]       i_llr_data,
    input  logic                         i_llr_last,
    output logic                         o_rdm_req,
    output logic                         o_comb_busy,
    output logic                         o_comb_done,
    output logic                         o_done_bank,
    output logic                         o_sat_flag,
    input  logic                         i_rd_bank,
    input  logic [ADDR_W-1:0]            i_rd_addr,
    output logic [LANES*ACC_W-1:0]       o_rd_data
);
    localparam int ROW_W = LANES * ACC_W;
    localparam int LSH   = $clog2(LANES);
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    typedef enum logic [2:0] {IDLE, WAIT, FILL, COMBINE, DONE} state_t;

    function automatic logic signed [ACC_W-1:0] sext_llr(input logic signed [LLR_W-1:0] v);
        return {{(ACC_W-LLR_W){v[LLR_W-1]}}, v};
    endfunction

`ifdef HARQ_COMB_SAT_EN
    // A one-bit-wider sum overflowed when its two top bits disagree.
    function automatic logic clipped(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
        if (!clipped(s))
            return s[ACC_W-1:0];
        else if (s[ACC_W])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                wbank_q;
    logic                rdm_req_q;
    logic [15:0]         ncb_q;
    logic [16:0]         rows_raw;
    logic [ADDR_W-1:0]   last_row;
    logic                accept;

    logic [ROW_W-1:0]    mem [0:DEPTH-1];
    logic [ROW_W-1:0]    rd_data_q;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic                bank_p1;
    logic                cmb_p1;
    logic [LANES*LLR_W-1:0] llr_p1;
    logic [ROW_W-1:0]    old_p1;

    logic [ROW_W-1:0]    wr_data;
    logic signed [ACC_W-1:0] old_l, new_l;
    logic signed [ACC_W:0]   sum_l;
`ifdef HARQ_COMB_SAT_EN
    logic                clip_any;
    logic                sat_q;
`endif

    // Row count = ceil(ncb/LANES), at least 1, at most the bank depth.
    always_comb begin
        rows_raw = ({1'b0, ncb_q} + 17'(LANES - 1)) >> LSH;
        if (rows_raw == 17'd0)
            last_row = '0;
        else if (rows_raw >= 17'(2 ** ADDR_W))
            last_row = '1;
        else
            last_row = ADDR_W'(rows_raw - 17'd1);
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:    if (i_comb_req) state_d = WAIT;
            WAIT:    if (i_harq_free) state_d = FILL;
            FILL, COMBINE: begin
                if (i_llr_valid) begin
                    accept = 1'b1;
                    wptr_d = (wptr_q == last_row) ? '0 : wptr_q + 1'b1;
                    // A last row ends the block even when it also wraps the pointer.
                    if (i_llr_last)
                        state_d = DONE;
                    else if (wptr_q == last_row)
                        state_d = COMBINE;
                end
            end
            DONE: begin
                state_d = IDLE;
                wptr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            wbank_q   <= 1'b0;
            rdm_req_q <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rdm_req_q <= (state_q == WAIT) && i_harq_free;
            vld_p1    <= accept;
            if (state_q == DONE)
                wbank_q <= ~wbank_q;
        end
    end

    // Stage p0 -> p1: capture accepted row and read the stored sum. A write
    // still pending to the same row is forwarded over the stale RAM word.
    always_ff @(posedge i_core_clk) begin
        if (state_q == IDLE && i_comb_req)
            ncb_q <= i_users_ncb[{i_user_idx, 4'b0000} +: 16];
        if (accept) begin
            addr_p1 <= wptr_q;
            bank_p1 <= wbank_q;
            cmb_p1  <= (state_q == COMBINE);
            llr_p1  <= i_llr_data;
            if (vld_p1 && addr_p1 == wptr_q && bank_p1 == wbank_q)
                old_p1 <= wr_data;
            else
                old_p1 <= mem[{wbank_q, wptr_q}];
        end
        if (vld_p1)
            mem[{bank_p1, addr_p1}] <= wr_data;
        rd_data_q <= mem[{i_rd_bank, i_rd_addr}];
    end

    // Stage p1: per-lane fill or accumulate, written back at the next edge.
    always_comb begin
        wr_data = '0;
        old_l   = '0;
        new_l   = '0;
        sum_l   = '0;
`ifdef HARQ_COMB_SAT_EN
        clip_any = 1'b0;
`endif
        for (int j = 0; j < LANES; j++) begin
            old_l = old_p1[j*ACC_W +: ACC_W];
            new_l = sext_llr(llr_p1[j*LLR_W +: LLR_W]);
            sum_l = {old_l[ACC_W-1], old_l} + {new_l[ACC_W-1], new_l};
            if (cmb_p1) begin
`ifdef HARQ_COMB_SAT_EN
                wr_data[j*ACC_W +: ACC_W] = sat_acc(sum_l);
                clip_any = clip_any | clipped(sum_l);
`else
                wr_data[j*ACC_W +: ACC_W] = sum_l[ACC_W-1:0];
`endif
            end else begin
                wr_data[j*ACC_W +: ACC_W] = new_l;
            end
        end
    end

`ifdef HARQ_COMB_SAT_EN
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst)
            sat_q <= 1'b0;
        else if (state_q == IDLE && i_comb_req)
            sat_q <= 1'b0;
        else if (vld_p1 && clip_any)
            sat_q <= 1'b1;
    end
    assign o_sat_flag = sat_q;
`else
    assign o_sat_flag = 1'b0;
`endif

    assign o_rdm_req   = rdm_req_q;
    assign o_comb_busy = (state_q != IDLE);
    assign o_comb_done = (state_q == DONE);
    assign o_done_bank = (state_q == DONE) & wbank_q;
    assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_harq_soft_combine.sv
// Scoreboard bench for harq_soft_combine: directed blocks push expected
// completion and readout results into queues; a negedge monitor pops and
// compares whenever the DUT signals completion or a readout is due.
module tb_harq_soft_combine;
    localparam int LANES     = 16;
    localparam int LLR_W     = 6;
    localparam int ACC_W     = 10;
    localparam int ADDR_W    = 11;
    localparam int NUM_USERS = 8;
    localparam int ROW_W     = LANES * ACC_W;

`ifdef HARQ_COMB_SAT_EN
    localparam logic SAT_EXP = 1'b1;
    localparam int   BIG_EXP = 511;
`else
    localparam logic SAT_EXP = 1'b0;
    localparam int   BIG_EXP = -404;
`endif

    logic                     clk = 1'b0;
    logic                     i_rx_rst;
    logic                     i_comb_req;
    logic [2:0]               i_user_idx;
    logic [16*NUM_USERS-1:0]  i_users_ncb;
    logic                     i_harq_free;
    logic                     i_llr_valid;
    logic [LANES*LLR_W-1:0]   i_llr_data;
    logic                     i_llr_last;
    logic                     o_rdm_req;
    logic                     o_comb_busy;
    logic                     o_comb_done;
    logic                     o_done_bank;
    logic                     o_sat_flag;
    logic                     i_rd_bank;
    logic [ADDR_W-1:0]        i_rd_addr;
    logic [ROW_W-1:0]         o_rd_data;

    always #5 clk = ~clk;

    harq_soft_combine #(
        .LANES(LANES), .LLR_W(LLR_W), .ACC_W(ACC_W),
        .ADDR_W(ADDR_W), .NUM_USERS(NUM_USERS)
    ) dut (
        .i_core_clk (clk),
        .i_rx_rst   (i_rx_rst),
        .i_comb_req (i_comb_req),
        .i_user_idx (i_user_idx),
        .i_users_ncb(i_users_ncb),
        .i_harq_free(i_harq_free),
        .i_llr_valid(i_llr_valid),
        .i_llr_data (i_llr_data),
        .i_llr_last (i_llr_last),
        .o_rdm_req  (o_rdm_req),
        .o_comb_busy(o_comb_busy),
        .o_comb_done(o_comb_done),
        .o_done_bank(o_done_bank),
        .o_sat_flag (o_sat_flag),
        .i_rd_bank  (i_rd_bank),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]       done_q [$];   // {bank, sat}
    logic [ROW_W-1:0] rd_exp_q [$];
    logic             rd_pend = 1'b0;
    logic             rd_vld  = 1'b0;

    always @(posedge clk) rd_vld <= rd_pend;

    function automatic logic [ROW_W-1:0] row_of(input int v);
        logic [ROW_W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*ACC_W +: ACC_W] = ACC_W'(v);
        return r;
    endfunction

    function automatic logic [LANES*LLR_W-1:0] llr_row(input int v);
        logic [LANES*LLR_W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*LLR_W +: LLR_W] = LLR_W'(v);
        return r;
    endfunction

    // Monitor: completion events and readout data against the queues.
    always @(negedge clk) begin : monitor
        logic [1:0]       de;
        logic [ROW_W-1:0] re;
        if (o_comb_done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done bank=%0d, required no done", o_done_bank);
            end else begin
                de = done_q.pop_front();
                if ({o_done_bank, o_sat_flag} !== de) begin
                    errors++;
                    $display("FAIL done_event: got bank=%0d sat=%0d, required bank=%0d sat=%0d",
                             o_done_bank, o_sat_flag, de[1], de[0]);
                end
            end
        end
        if (rd_vld) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL readout_unexpected: no expected value queued");
            end else begin
                re = rd_exp_q.pop_front();
                if (o_rd_data !== re) begin
                    errors++;
                    $display("FAIL readout lane0: got %0d, required %0d (full row %h vs %h)",
                             $signed(o_rd_data[ACC_W-1:0]), $signed(re[ACC_W-1:0]), o_rd_data, re);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic start(input int user, input int ncb);
        i_users_ncb[16*user +: 16] = 16'(ncb);
        i_user_idx = 3'(user);
        i_comb_req = 1'b1;
        tick();
        i_comb_req = 1'b0;
    endtask

    task automatic wait_rdm(input string name);
        int n;
        n = 0;
        while (o_rdm_req !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (o_rdm_req !== 1'b1) begin
            errors++;
            $display("FAIL %s rdm_req: got 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_comb_busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (o_comb_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic send_rows(input int n, input int v, input logic last);
        for (int i = 0; i < n; i++) begin
            i_llr_valid = 1'b1;
            i_llr_data  = llr_row(v);
            i_llr_last  = last && (i == n - 1);
            tick();
        end
        i_llr_valid = 1'b0;
        i_llr_last  = 1'b0;
    endtask

    task automatic read_row(input logic bank, input int addr, input int v);
        i_rd_bank = bank;
        i_rd_addr = ADDR_W'(addr);
        rd_exp_q.push_back(row_of(v));
        rd_pend = 1'b1;
        tick();
        rd_pend = 1'b0;
    endtask

    initial begin
        i_rx_rst    = 1'b1;
        i_comb_req  = 1'b0;
        i_user_idx  = '0;
        i_users_ncb = '0;
        i_harq_free = 1'b1;
        i_llr_valid = 1'b0;
        i_llr_data  = '0;
        i_llr_last  = 1'b0;
        i_rd_bank   = 1'b0;
        i_rd_addr   = '0;
        repeat (3) tick();
        chk("rst_rdm_req", o_rdm_req, 0);
        chk("rst_busy", o_comb_busy, 0);
        chk("rst_done", o_comb_done, 0);
        chk("rst_done_bank", o_done_bank, 0);
        chk("rst_sat", o_sat_flag, 0);
        i_rx_rst = 1'b0;
        tick();

        // ncb=64: four fill rows of +5 into bank0, last on the wrapping row.
        start(2, 64);
        chk("s1_busy", o_comb_busy, 1);
        wait_rdm("s1");
        done_q.push_back({1'b0, 1'b0});
        send_rows(4, 5, 1'b1);
        wait_idle("s1");
        for (int r = 0; r < 4; r++) read_row(1'b0, r, 5);

        // Reset while combining into bank1: no done, bank select back to 0.
        start(3, 32);
        wait_rdm("s5");
        send_rows(3, 2, 1'b0);
        i_rx_rst = 1'b1;
        tick();
        i_rx_rst = 1'b0;
        chk("s5_busy_after_rst", o_comb_busy, 0);
        chk("s5_done_after_rst", o_comb_done, 0);
        repeat (3) tick();
        start(4, 16);
        wait_rdm("s5b");
        done_q.push_back({1'b0, 1'b0});
        send_rows(1, 1, 1'b1);
        wait_idle("s5b");
        read_row(1'b0, 0, 1);

        // ncb=32 (2 rows), five rows of +3 into bank1: row0=9, row1=6.
        start(5, 32);
        wait_rdm("s2");
        done_q.push_back({1'b1, 1'b0});
        send_rows(5, 3, 1'b1);
        wait_idle("s2");
        read_row(1'b1, 0, 9);
        read_row(1'b1, 1, 6);

        // ncb=16 (1 row), three back-to-back rows of -7 into bank0.
        start(0, 16);
        wait_rdm("s3");
        done_q.push_back({1'b0, 1'b0});
        send_rows(3, -7, 1'b1);
        wait_idle("s3");
        read_row(1'b0, 0, -21);

        // ncb=16, twenty rows of +31 into bank1: saturates or wraps.
        start(1, 16);
        wait_rdm("s4");
        done_q.push_back({1'b1, SAT_EXP});
        send_rows(20, 31, 1'b1);
        wait_idle("s4");
        chk("s4_sat_sticky", o_sat_flag, SAT_EXP);
        read_row(1'b1, 0, BIG_EXP);

        // Bank held by readout for 10 cycles; offered rows must be ignored.
        i_harq_free = 1'b0;
        start(7, 16);
        for (int c = 0; c < 10; c++) begin
            i_llr_valid = 1'b1;
            i_llr_data  = llr_row(9);
            i_llr_last  = 1'b1;
            chk("s6_rdm_held", o_rdm_req, 0);
            chk("s6_busy_held", o_comb_busy, 1);
            tick();
        end
        i_llr_valid = 1'b0;
        i_llr_last  = 1'b0;
        chk("s6_sat_cleared", o_sat_flag, 0);
        i_harq_free = 1'b1;
        wait_rdm("s6");
        done_q.push_back({1'b0, 1'b0});
        send_rows(1, 4, 1'b1);
        wait_idle("s6");
        read_row(1'b0, 0, 4);

        repeat (3) tick();
        chk("done_events_outstanding", done_q.size(), 0);
        chk("readouts_outstanding", rd_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
